ser_word_rx: RTL

Serial-to-parallel word receiver. It is the receiving end of the MSB-first serial stream produced by the shift-left parallel-load shift register.
- Detects a start bit, shifts in `size` data bits and checks a stop bit.
- Presents each completed word in a holding register with a valid/ready handshake to the consuming datapath.
- Reports framing and overrun errors as sticky flags.

---
 rtl/ser_pkg.sv | 21 ++
 rtl/ser_bit_cnt.sv | 29 ++
 rtl/ser_word_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ser_pkg
// Description : Shared types and frame constants for the serial word receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_SHIFT = 2'd1,
        SER_STOP  = 2'd2
    } ser_state_t;

    // A frame opens with a 1 and closes with a 0, so an idle-low line never
    // looks like a start bit.
    localparam logic SER_START_BIT = 1'b1;
    localparam logic SER_STOP_BIT  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ser_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ser_bit_cnt
// Description : Up-counter with synchronous clear (priority) and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_bit_cnt #(
    parameter int bits = 6
) (
    input  logic            clk,
    input  logic            r,
    input  logic            clr,
    input  logic            en,
    output logic [bits-1:0] c
);

    // Clear wins over enable so a new frame always restarts from zero.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            c <= '0;
        end else if (clr) begin
            c <= '0;
        end else if (en) begin
            c <= c + bits'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ser_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : ser_word_rx
// Description : MSB-first serial-to-parallel word receiver with start/stop
//               framing, valid/ready holding register and sticky
//               framing/overrun error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_word_rx
    import ser_pkg::*;
#(
    parameter int size     = 32,
    parameter int cnt_bits = 6
) (
    input  logic            clk,
    input  logic            r,
    input  logic            si,
    input  logic            sv,
    output logic [size-1:0] q,
    output logic            q_valid,
    input  logic            q_ready,
    output logic            frame_err,
    output logic            overrun,
    input  logic            clr_err,
    output logic            busy
);

    localparam logic [cnt_bits-1:0] LAST_BIT = cnt_bits'(size - 1);

    ser_state_t          state;
    ser_state_t          state_nxt;
    logic [size-1:0]     sreg;
    logic [cnt_bits-1:0] cnt;
    logic                cnt_clr;
    logic                cnt_en;
    logic                load;
    logic                drop;
    logic                bad_stop;
    logic                xfer;
    logic                last;

    assign last = (cnt == LAST_BIT);
    assign xfer = q_valid & q_ready;

    ser_bit_cnt #(
        .bits (cnt_bits)
    ) u_bit_cnt (
        .clk (clk),
        .r   (r),
        .clr (cnt_clr),
        .en  (cnt_en),
        .c   (cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state <= SER_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: every move is qualified by the serial strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            SER_IDLE:  if (sv && (si == SER_START_BIT)) state_nxt = SER_SHIFT;
            SER_SHIFT: if (sv && last)                  state_nxt = SER_STOP;
            SER_STOP:  if (sv)                          state_nxt = SER_IDLE;
            default:                                    state_nxt = SER_IDLE;
        endcase
    end

    // Decoded controls for counter, shifter, holding register and flags.
    always_comb begin
        busy     = (state != SER_IDLE);
        cnt_clr  = (state == SER_IDLE) && sv && (si == SER_START_BIT);
        cnt_en   = (state == SER_SHIFT) && sv;
        load     = 1'b0;
        drop     = 1'b0;
        bad_stop = 1'b0;
        if ((state == SER_STOP) && sv) begin
            if (si != SER_STOP_BIT) begin
                bad_stop = 1'b1;
            end else if (!q_valid || q_ready) begin
                load = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Data bits enter at the LSB so the first (MSB) bit ends up on top.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            sreg <= '0;
        end else if (cnt_en) begin
            sreg <= {sreg[size-2:0], si};
        end
    end

    // Holding register: a load in the same cycle as a transfer keeps valid high.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= sreg;
            q_valid <= 1'b1;
        end else if (xfer) begin
            q_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error event beats a simultaneous clear.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bad_stop) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
